// File: rtl/id_decode_stage.sv
// RV32I decode stage: control, immediates and illegal detection, registered with a 1-cycle latency.
// Handshake: in_ready = !out_valid || out_ready, so the stage stalls while execute holds off.
module id_decode_stage #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_regwrite,
  output logic               out_memread,
  output logic               out_memwrite,
  output logic               out_memtoreg,
  output logic               out_alusrc,
  output logic               out_alusrc_pc,
  output logic               out_branch,
  output logic               out_jump,
  output logic [ALUOP_W-1:0] out_aluop,
  output logic [XLEN-1:0]    out_imm,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [4:0]         out_rd,
  output logic [XLEN-1:0]    out_pc,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   illegal_count
);

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(10);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               alusrc;
    logic               alusrc_pc;
    logic               branch;
    logic               jump;
    logic               illegal;
    logic [ALUOP_W-1:0] aluop;
    logic [XLEN-1:0]    imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [XLEN-1:0]    pc;
  } bundle_t;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // alt selects the funct7=20h variant (SUB for 000, SRA for 101)
  function automatic logic [ALUOP_W-1:0] alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        legal;
  logic        accept;
  bundle_t     dec;
  bundle_t     bundle_d, bundle_q;
  logic        valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    dec     = '0;
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.rd  = in_instr[11:7];
    dec.pc  = in_pc;
    legal   = 1'b1;
    case (opcode)
      OP_R: begin
        dec.regwrite = 1'b1;
        dec.aluop    = alu_sel(funct3, funct7[5]);
        legal = (funct7 == 7'h00) ||
                (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OP_IMM: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.imm      = sext(imm_i);
        dec.aluop    = alu_sel(funct3, funct3 == 3'b101 && funct7[5]);
        if (funct3 == 3'b001)
          legal = (funct7 == 7'h00);
        else if (funct3 == 3'b101)
          legal = (funct7 == 7'h00) || (funct7 == 7'h20);
      end
      OP_LUI: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.imm      = sext(imm_u);
        dec.rs1      = 5'd0;
      end
      OP_AUIPC: begin
        dec.regwrite  = 1'b1;
        dec.alusrc    = 1'b1;
        dec.alusrc_pc = 1'b1;
        dec.imm       = sext(imm_u);
      end
      OP_LOAD: begin
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.alusrc   = 1'b1;
        dec.imm      = sext(imm_i);
      end
      OP_STORE: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.imm      = sext(imm_s);
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        dec.aluop  = ALU_SUB;
        dec.imm    = sext(imm_b);
      end
      OP_JAL: begin
        dec.regwrite = 1'b1;
        dec.jump     = 1'b1;
        dec.imm      = sext(imm_j);
      end
      OP_JALR: begin
        dec.regwrite = 1'b1;
        dec.jump     = 1'b1;
        dec.alusrc   = 1'b1;
        dec.imm      = sext(imm_i);
      end
      default: legal = 1'b0;
    endcase
    if (in_instr[1:0] != 2'b11) legal = 1'b0;
    // Illegal bundles keep register indices and PC for trap reporting; all side effects off
    if (!legal) begin
      dec.regwrite  = 1'b0;
      dec.memread   = 1'b0;
      dec.memwrite  = 1'b0;
      dec.memtoreg  = 1'b0;
      dec.alusrc    = 1'b0;
      dec.alusrc_pc = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.aluop     = ALU_ADD;
      dec.imm       = '0;
      dec.illegal   = 1'b1;
    end
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    cnt_d    = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      bundle_d = dec;
      if (dec.illegal && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_regwrite  = bundle_q.regwrite;
  assign out_memread   = bundle_q.memread;
  assign out_memwrite  = bundle_q.memwrite;
  assign out_memtoreg  = bundle_q.memtoreg;
  assign out_alusrc    = bundle_q.alusrc;
  assign out_alusrc_pc = bundle_q.alusrc_pc;
  assign out_branch    = bundle_q.branch;
  assign out_jump      = bundle_q.jump;
  assign out_aluop     = bundle_q.aluop;
  assign out_imm       = bundle_q.imm;
  assign out_rs1       = bundle_q.rs1;
  assign out_rs2       = bundle_q.rs2;
  assign out_rd        = bundle_q.rd;
  assign out_pc        = bundle_q.pc;
  assign out_illegal   = bundle_q.illegal;
  assign illegal_count = cnt_q;

endmodule
